// File: rtl/pipe_mem_stage.sv
// MEM stage of the pipelined CPU plus the MEM/WB register: drives a variable-latency data
// memory over a req/ready handshake, stalls upstream while an access is pending, flags faults.
module pipe_mem_stage #(
  parameter int WAIT_LIMIT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mvalid,
  input  logic        mwreg,
  input  logic        mm2reg,
  input  logic        mwmem,
  input  logic [31:0] malu,
  input  logic [31:0] mb,
  input  logic [4:0]  mrn,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ready,
  output logic        mem_stall,
  output logic        wvalid,
  output logic        wwreg,
  output logic        wm2reg,
  output logic [31:0] wmo,
  output logic [31:0] walu,
  output logic [4:0]  wrn,
  output logic        wexc,
  output logic [1:0]  wcause,
  output logic        dbg_state
);

  // Handshake: dmem_req is held with stable we/addr/wdata until the cycle dmem_ready=1;
  // that cycle completes the access. dmem_ready with dmem_req=0 has no effect.

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  localparam logic [7:0] LIMIT = 8'(WAIT_LIMIT);

  state_t     state;
  logic [7:0] wcnt;
  logic       memop;
  logic       mis;
  logic       abort;
  logic       done;

  assign memop = mvalid & (mm2reg | mwmem) & ~rst;
  assign mis   = memop & (malu[1:0] != 2'b00);

  assign dmem_req   = ~rst & (((state == IDLE) & memop & ~mis) | (state == WAIT));
  assign dmem_we    = mwmem;
  assign dmem_addr  = malu;
  assign dmem_wdata = mb;

  // Ready beats the limit when both land in the same cycle.
  assign abort     = ~rst & (state == WAIT) & (wcnt == LIMIT) & ~dmem_ready;
  assign done      = dmem_req & dmem_ready;
  assign mem_stall = dmem_req & ~dmem_ready & ~abort;
  assign dbg_state = (state == WAIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      wcnt  <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (dmem_req & ~dmem_ready) begin
            state <= WAIT;
            wcnt  <= 8'd1;
          end
        end
        WAIT: begin
          if (dmem_ready | abort) begin
            state <= IDLE;
            wcnt  <= 8'd0;
          end else if (wcnt != LIMIT) begin
            wcnt <= wcnt + 8'd1;
          end
        end
        default: begin
          state <= IDLE;
          wcnt  <= 8'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wvalid <= 1'b0;
      wwreg  <= 1'b0;
      wm2reg <= 1'b0;
      wmo    <= 32'd0;
      walu   <= 32'd0;
      wrn    <= 5'd0;
      wexc   <= 1'b0;
      wcause <= 2'b00;
    end else if (mem_stall) begin
      // Bubble into WB; data fields keep their last values.
      wvalid <= 1'b0;
      wwreg  <= 1'b0;
      wexc   <= 1'b0;
      wcause <= 2'b00;
    end else begin
      wvalid <= mvalid;
      wwreg  <= mvalid & mwreg & ~mis & ~abort;
      wm2reg <= mm2reg;
      walu   <= malu;
      wrn    <= mrn;
      wexc   <= mis | abort;
      wcause <= mis ? 2'b01 : (abort ? 2'b10 : 2'b00);
      if (done & ~mwmem) wmo <= dmem_rdata;
    end
  end

endmodule

// File: tb/tb_pipe_mem_stage.sv
// Directed bench for pipe_mem_stage: a driver issues MEM-stage instructions and pushes the
// expected WB record; a monitor pops and compares whenever wvalid is presented.
module tb_pipe_mem_stage;

  localparam int W = 74;

  logic        clk;
  logic        rst;
  logic        mvalid, mwreg, mm2reg, mwmem;
  logic [31:0] malu, mb;
  logic [4:0]  mrn;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        dmem_ready;
  logic        mem_stall;
  logic        wvalid, wwreg, wm2reg;
  logic [31:0] wmo, walu;
  logic [4:0]  wrn;
  logic        wexc;
  logic [1:0]  wcause;
  logic        dbg_state;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_q[$];

  pipe_mem_stage #(.WAIT_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .mvalid(mvalid), .mwreg(mwreg), .mm2reg(mm2reg), .mwmem(mwmem),
    .malu(malu), .mb(mb), .mrn(mrn),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
    .mem_stall(mem_stall),
    .wvalid(wvalid), .wwreg(wwreg), .wm2reg(wm2reg), .wmo(wmo), .walu(walu),
    .wrn(wrn), .wexc(wexc), .wcause(wcause), .dbg_state(dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] rec(input logic r_wwreg, input logic r_wm2reg,
                                       input logic r_wexc, input logic [1:0] r_cause,
                                       input logic [4:0] r_rn, input logic [31:0] r_alu,
                                       input logic [31:0] r_mo);
    return {r_wwreg, r_wm2reg, r_wexc, r_cause, r_rn, r_alu, r_mo};
  endfunction

  // Scoreboard monitor
  always @(posedge clk) begin
    #1;
    if (wvalid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_wb", 80'(walu), 80'hFFFF_FFFF_FFFF_FFFF_FFFF);
      end else begin
        check("wb_record", 80'({wwreg, wm2reg, wexc, wcause, wrn, walu, wmo}),
              80'(exp_q.pop_front()));
      end
    end
  end

  task automatic idle_inputs();
    mvalid = 1'b0; mwreg = 1'b0; mm2reg = 1'b0; mwmem = 1'b0;
    malu = 32'd0; mb = 32'd0; mrn = 5'd0;
    dmem_ready = 1'b0; dmem_rdata = 32'd0;
  endtask

  // Driver: presents one instruction from a negedge and keeps it until the stall drops.
  // ready_at = cycle index at which memory answers (-1 = never).
  task automatic issue(input logic i_wreg, input logic i_m2reg, input logic i_wmem,
                       input logic [31:0] i_alu, input logic [31:0] i_b, input logic [4:0] i_rn,
                       input int ready_at, input logic [31:0] rdata, input logic exp_req,
                       output int stalls);
    int cyc;
    @(negedge clk);
    mvalid = 1'b1; mwreg = i_wreg; mm2reg = i_m2reg; mwmem = i_wmem;
    malu = i_alu; mb = i_b; mrn = i_rn; dmem_rdata = rdata;
    stalls = 0;
    cyc = 0;
    forever begin
      dmem_ready = (ready_at == cyc);
      #1;
      check("dmem_req", 80'(dmem_req), 80'(exp_req));
      if (exp_req) begin
        check("dmem_bus", 80'({dmem_we, dmem_addr, dmem_wdata}), 80'({i_wmem, i_alu, i_b}));
      end
      if (mem_stall !== 1'b1) break;
      stalls++;
      cyc++;
      if (cyc > 50) begin
        check("stall_bound", 80'(cyc), 80'd0);
        break;
      end
      @(negedge clk);
    end
  endtask

  int st;
  logic [31:0] last_mo;

  initial begin
    idle_inputs();
    rst = 1'b1;
    last_mo = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_wb", 80'({wvalid, wwreg, wm2reg, wexc, wcause, wrn, walu, wmo}), 80'd0);
    check("reset_req_stall", 80'({dmem_req, mem_stall, dbg_state}), 80'd0);
    @(negedge clk);
    rst = 1'b0;

    // Zero-wait load
    last_mo = 32'hDEADBEEF;
    exp_q.push_back(rec(1'b1, 1'b1, 1'b0, 2'b00, 5'd5, 32'h100, last_mo));
    issue(1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 5'd5, 0, 32'hDEADBEEF, 1'b1, st);
    check("zw_load_stalls", 80'(st), 80'd0);

    // 3-wait store: three bubbles, then a non-writing WB entry
    exp_q.push_back(rec(1'b0, 1'b0, 1'b0, 2'b00, 5'd0, 32'h200, last_mo));
    issue(1'b0, 1'b0, 1'b1, 32'h200, 32'h1234, 5'd0, 3, 32'h5555_5555, 1'b1, st);
    check("store_stalls", 80'(st), 80'd3);

    // Misaligned load with a stray ready: ignored, wmo holds
    exp_q.push_back(rec(1'b0, 1'b1, 1'b1, 2'b01, 5'd7, 32'h102, last_mo));
    issue(1'b1, 1'b1, 1'b0, 32'h102, 32'h0, 5'd7, 0, 32'hBAD0_BAD0, 1'b0, st);
    check("mis_load_stalls", 80'(st), 80'd0);

    // Misaligned store must never reach memory
    exp_q.push_back(rec(1'b0, 1'b0, 1'b1, 2'b01, 5'd0, 32'h203, last_mo));
    issue(1'b0, 1'b0, 1'b1, 32'h203, 32'hCAFE, 5'd0, -1, 32'h0, 1'b0, st);
    check("mis_store_stalls", 80'(st), 80'd0);

    // Timeout with limit 4: abort on 5th cycle
    exp_q.push_back(rec(1'b0, 1'b1, 1'b1, 2'b10, 5'd9, 32'h300, last_mo));
    issue(1'b1, 1'b1, 1'b0, 32'h300, 32'h0, 5'd9, -1, 32'h0, 1'b1, st);
    check("timeout_stalls", 80'(st), 80'd4);
    @(negedge clk);
    idle_inputs();
    #1;
    check("req_after_abort", 80'({dmem_req, dbg_state}), 80'd0);

    // Ready arriving exactly at the limit wins over the abort
    last_mo = 32'h0BAD_F00D;
    exp_q.push_back(rec(1'b1, 1'b1, 1'b0, 2'b00, 5'd11, 32'h304, last_mo));
    issue(1'b1, 1'b1, 1'b0, 32'h304, 32'h0, 5'd11, 4, 32'h0BAD_F00D, 1'b1, st);
    check("ready_at_limit_stalls", 80'(st), 80'd4);

    // Reset in the 2nd WAIT cycle
    @(negedge clk);
    mvalid = 1'b1; mwreg = 1'b1; mm2reg = 1'b1; mwmem = 1'b0;
    malu = 32'h400; mrn = 5'd3; dmem_ready = 1'b0;
    #1 check("rst_case_stall0", 80'(mem_stall), 80'd1);
    @(negedge clk);
    #1 check("rst_case_stall1", 80'(mem_stall), 80'd1);
    @(negedge clk);
    #1 check("rst_case_stall2", 80'(mem_stall), 80'd1);
    rst = 1'b1;
    #1 check("rst_comb", 80'({dmem_req, mem_stall}), 80'd0);
    @(posedge clk);
    #1;
    check("rst_mid_wb", 80'({wvalid, wwreg, wm2reg, wexc, wcause, wrn, walu, wmo}), 80'd0);
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    last_mo = 32'h1111_2222;
    exp_q.push_back(rec(1'b1, 1'b1, 1'b0, 2'b00, 5'd6, 32'h104, last_mo));
    issue(1'b1, 1'b1, 1'b0, 32'h104, 32'h0, 5'd6, 0, 32'h1111_2222, 1'b1, st);
    check("post_rst_load_stalls", 80'(st), 80'd0);

    // Back-to-back ALU, 1-wait load, ALU
    exp_q.push_back(rec(1'b1, 1'b0, 1'b0, 2'b00, 5'd1, 32'h0000_0055, last_mo));
    issue(1'b1, 1'b0, 1'b0, 32'h0000_0055, 32'h0, 5'd1, -1, 32'h0, 1'b0, st);
    check("alu1_stalls", 80'(st), 80'd0);
    last_mo = 32'hA5A5_5A5A;
    exp_q.push_back(rec(1'b1, 1'b1, 1'b0, 2'b00, 5'd2, 32'h108, last_mo));
    issue(1'b1, 1'b1, 1'b0, 32'h108, 32'h0, 5'd2, 1, 32'hA5A5_5A5A, 1'b1, st);
    check("b2b_load_stalls", 80'(st), 80'd1);
    exp_q.push_back(rec(1'b1, 1'b0, 1'b0, 2'b00, 5'd4, 32'h0000_0077, last_mo));
    issue(1'b1, 1'b0, 1'b0, 32'h0000_0077, 32'h0, 5'd4, 0, 32'hFFFF_0000, 1'b0, st);
    check("alu2_stalls", 80'(st), 80'd0);

    @(negedge clk);
    idle_inputs();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    check("exp_q_drained", 80'(exp_q.size()), 80'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
